// File: rtl/k005297_abspgcntr.sv
// k005297_abspgcntr: absolute bubble page counter plus seek/access sequencer feeding bubctrlfe.
// Define K005297_ABSPG_TIMEOUT_EN to build the seek timeout counter and o_SEEK_ERR.
module k005297_abspgcntr #(
   parameter int PAGE_COUNT = 2053
) (
   input  logic        i_MCLK,
   input  logic        i_SYS_RST_n,
   input  logic        i_CLK2M_PCEN_n,
   input  logic [19:0] i_ROT20_n,
   input  logic        i_CMD_REQ,
   input  logic [11:0] i_TARGET_PG,
   input  logic [11:0] i_PG_LEN,
   input  logic        i_ABORT,
   input  logic        i_BSEN_n,
   output logic        o_ABSPGCNTR_CNT_START,
   output logic        o_ABSPGCNTR_CNT_STOP,
   output logic        o_VALPG_ACC_FLAG,
   output logic [11:0] o_ABSPG,
   output logic        o_BUSY,
   output logic        o_SEEK_ERR
);
   typedef enum logic [2:0] {IDLE, START, SEEK, ACCESS, STOP} state_t;
   localparam logic [11:0] LAST_PG  = 12'(PAGE_COUNT - 1);
   localparam logic [4:0]  HOLD_END = 5'd19;
   state_t      state_q, state_d;
   logic [11:0] abspg_q, abspg_d, tgt_q, tgt_d, len_q, len_d, rem_q, rem_d;
   logic [4:0]  hold_q, hold_d;
   logic        flag_q, flag_d, start_q, stop_q, busy_q;
   logic        en, tick, match, seek_tmo;
   logic        rot_unused;
   assign rot_unused = ^i_ROT20_n[18:0];
   assign en      = ~i_CLK2M_PCEN_n;
   assign tick    = en & ~i_ROT20_n[19] & ~i_BSEN_n;
   assign abspg_d = tick ? ((abspg_q == LAST_PG) ? 12'd0 : abspg_q + 12'd1) : abspg_q;
   // abspg_d is the post-increment page, so a target equal to the entry page needs a full loop
   assign match   = tick & (abspg_d == tgt_q);
`ifdef K005297_ABSPG_TIMEOUT_EN
   localparam logic [12:0] TMO_TICKS = 13'(PAGE_COUNT + 1);
   logic [12:0] seek_cnt_q, seek_cnt_d;
   logic        err_q, err_d, accept, seek_fail;
   assign seek_tmo   = tick & (seek_cnt_q + 13'd1 == TMO_TICKS);
   assign seek_cnt_d = (state_q != SEEK) ? 13'd0 : (tick ? seek_cnt_q + 13'd1 : seek_cnt_q);
   assign accept     = en & ~i_ABORT & (state_q == IDLE) & i_CMD_REQ;
   assign seek_fail  = en & ~i_ABORT & (state_q == SEEK) & seek_tmo & ~match;
   assign err_d      = accept ? 1'b0 : (seek_fail ? 1'b1 : err_q);
   always_ff @(posedge i_MCLK or negedge i_SYS_RST_n)
      if (!i_SYS_RST_n) begin
         seek_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         seek_cnt_q <= seek_cnt_d;
         err_q      <= err_d;
      end
   assign o_SEEK_ERR = err_q;
`else
   assign seek_tmo   = 1'b0;
   assign o_SEEK_ERR = 1'b0;
`endif
   always_comb begin
      state_d = state_q;
      tgt_d   = tgt_q;
      len_d   = len_q;
      rem_d   = rem_q;
      hold_d  = hold_q;
      flag_d  = flag_q;
      if (en) begin
         if (i_ABORT) begin
            // bubbles not yet shifting can be dropped outright; otherwise stop the shift cleanly
            if (state_q != IDLE) begin
               state_d = ((state_q == START || state_q == SEEK) && i_BSEN_n) ? IDLE : STOP;
               flag_d  = 1'b0;
            end
         end else begin
            case (state_q)
               IDLE: if (i_CMD_REQ) begin
                  state_d = START;
                  tgt_d   = i_TARGET_PG;
                  len_d   = i_PG_LEN;
                  hold_d  = 5'd0;
               end
               START: begin
                  hold_d = (hold_q == HOLD_END) ? hold_q : hold_q + 5'd1;
                  if (hold_q == HOLD_END && !i_BSEN_n) state_d = SEEK;
               end
               SEEK: begin
                  if (match) begin
                     state_d = (len_q != 12'd0) ? ACCESS : STOP;
                     rem_d   = len_q;
                     flag_d  = (len_q != 12'd0);
                  end else if (seek_tmo) begin
                     state_d = STOP;
                  end
               end
               ACCESS: if (tick) begin
                  rem_d = rem_q - 12'd1;
                  if (rem_q == 12'd1) begin
                     flag_d  = 1'b0;
                     state_d = STOP;
                  end
               end
               STOP: if (i_BSEN_n) state_d = IDLE;
               default: state_d = IDLE;
            endcase
         end
      end
   end
   always_ff @(posedge i_MCLK or negedge i_SYS_RST_n)
      if (!i_SYS_RST_n) begin
         state_q <= IDLE;
         abspg_q <= '0;
         tgt_q   <= '0;
         len_q   <= '0;
         rem_q   <= '0;
         hold_q  <= '0;
         flag_q  <= 1'b0;
         start_q <= 1'b0;
         stop_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         abspg_q <= abspg_d;
         tgt_q   <= tgt_d;
         len_q   <= len_d;
         rem_q   <= rem_d;
         hold_q  <= hold_d;
         flag_q  <= flag_d;
         start_q <= (state_d == START);
         stop_q  <= (state_d == STOP);
         busy_q  <= (state_d != IDLE);
      end
   assign o_ABSPGCNTR_CNT_START = start_q;
   assign o_ABSPGCNTR_CNT_STOP  = stop_q;
   assign o_VALPG_ACC_FLAG      = flag_q;
   assign o_ABSPG               = abspg_q;
   assign o_BUSY                = busy_q;
endmodule

// File: tb/tb_k005297_abspgcntr.sv
// tb_k005297_abspgcntr: bench for the absolute page counter; honours K005297_ABSPG_TIMEOUT_EN.
module tb_k005297_abspgcntr;
   localparam int P = 2053;
   typedef struct {
      bit pcen_n;
      bit ph19;
      bit bsen_n;
      int inc;
   } vec_t;
   logic        clk, rst_n, pcen_n, cmd_req, abort, bsen_n;
   logic [19:0] rot_n;
   logic [11:0] tgt_pg, pg_len, abspg;
   logic        cnt_start, cnt_stop, flag, busy, seek_err;
   int checks, errors, mpg, ph, last_pg0, n, pg_before;
   bit fast, last_tick;
   vec_t tbl[8];

   k005297_abspgcntr #(.PAGE_COUNT(P)) dut (
      .i_MCLK(clk), .i_SYS_RST_n(rst_n), .i_CLK2M_PCEN_n(pcen_n), .i_ROT20_n(rot_n),
      .i_CMD_REQ(cmd_req), .i_TARGET_PG(tgt_pg), .i_PG_LEN(pg_len), .i_ABORT(abort),
      .i_BSEN_n(bsen_n), .o_ABSPGCNTR_CNT_START(cnt_start), .o_ABSPGCNTR_CNT_STOP(cnt_stop),
      .o_VALPG_ACC_FLAG(flag), .o_ABSPG(abspg), .o_BUSY(busy), .o_SEEK_ERR(seek_err));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic set_ph(input int p);
      ph    = p;
      rot_n = ~(20'd1 << p);
   endtask

   // one MCLK edge; the page model is plain modular counting of qualified ticks
   task automatic clk1();
      last_tick = rst_n && !pcen_n && ph == 19 && !bsen_n;
      @(posedge clk);
      #1;
      if (!rst_n) mpg = 0;
      else if (last_tick) mpg = (mpg == P - 1) ? 0 : mpg + 1;
      if (!pcen_n && !fast) set_ph((ph + 1) % 20);
   endtask

   task automatic goto_pg(input int pg);
      int guard;
      fast = 1; set_ph(19); bsen_n = 0; guard = 0;
      while (mpg != pg && guard < P + 5) begin clk1(); guard++; end
      chk("goto_pg", abspg, pg);
   endtask

   task automatic issue_start(input int tgt, input int len);
      int guard;
      bsen_n = 1; cmd_req = 1; tgt_pg = 12'(tgt); pg_len = 12'(len);
      clk1();
      chk("start_rise", cnt_start, 1);
      chk("busy_rise", busy, 1);
      cmd_req = 0;
      repeat (20) clk1();
      chk("start_hold", cnt_start, 1);
      bsen_n = 0; guard = 0;
      while (cnt_start && guard < 40) begin clk1(); guard++; end
      chk("seek_entry", cnt_start, 0);
      last_pg0 = abspg;
   endtask

   task automatic do_cmd(input int tgt, input int len, input int abort_at);
      int d, fp, first_pg, budget;
      bit done;
      issue_start(tgt, len);
      d = (tgt - last_pg0 + P) % P;
      if (d == 0) d = P;
      n = 0; fp = 0; first_pg = -1; done = 0;
      budget = (fast ? 1 : 20) * (P + 20) + 50;
      while (!done && budget > 0) begin
         clk1(); budget--;
         if (last_tick) n++;
         if (flag && last_tick) begin
            fp++;
            if (first_pg < 0) begin
               first_pg = abspg;
               chk("flag_page", first_pg, tgt);
               chk("flag_ticks", n, d);
            end
         end
         if (abort_at >= 0 && fp == abort_at && flag) begin
            abort = 1; clk1(); abort = 0;
            chk("abort_flag", flag, 0);
            chk("abort_stop", cnt_stop, 1);
            done = 1;
         end else if (cnt_stop) begin
            chk("stop_ticks", n, d + len);
            chk("stop_page", abspg, (tgt + len) % P);
            chk("stop_flag", flag, 0);
            chk("flag_pages", fp, len);
            done = 1;
         end
      end
      chk("cmd_done", done, 1);
      bsen_n = 1;
      clk1();
      chk("idle_busy", busy, 0);
      chk("idle_stop", cnt_stop, 0);
   endtask

   initial begin
      checks = 0; errors = 0; mpg = 0; fast = 0;
      rst_n = 0; pcen_n = 0; cmd_req = 0; abort = 0; bsen_n = 1;
      tgt_pg = 0; pg_len = 0; set_ph(0);
      tbl = '{'{0, 1, 0, 1}, '{0, 1, 1, 0}, '{0, 0, 0, 0}, '{0, 0, 1, 0},
              '{1, 1, 0, 0}, '{1, 1, 1, 0}, '{1, 0, 0, 0}, '{1, 0, 1, 0}};
      repeat (3) clk1();
      chk("rst_start", cnt_start, 0);
      chk("rst_stop", cnt_stop, 0);
      chk("rst_flag", flag, 0);
      chk("rst_pg", abspg, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", seek_err, 0);
      rst_n = 1; set_ph(0); bsen_n = 0;
      repeat (40 * 20) clk1();
      chk("pg_40", abspg, 40);
      foreach (tbl[i]) begin
         pcen_n = tbl[i].pcen_n; bsen_n = tbl[i].bsen_n;
         set_ph(tbl[i].ph19 ? 19 : 0);
         pg_before = abspg;
         clk1();
         chk($sformatf("tick_vec%0d", i), abspg, pg_before + tbl[i].inc);
      end
      pcen_n = 0;
      goto_pg(2052);
      clk1();
      chk("wrap", abspg, 0);
      fast = 0;
      for (int i = 0; i < 300; i++) begin
         pcen_n = 1'($urandom_range(0, 1));
         bsen_n = 1'($urandom_range(0, 1));
         set_ph($urandom_range(0, 19));
         clk1();
         chk("rand_pg", abspg, mpg);
         chk("rand_busy", busy, 0);
      end
      pcen_n = 0;
      goto_pg(5);
      fast = 0; set_ph(0);
      do_cmd(8, 3, -1);
      goto_pg(7);
      fast = 0; set_ph(0);
      do_cmd(10, 0, -1);
      goto_pg(99);
      do_cmd(100, 1, -1);
      chk("same_pg_entry", last_pg0, 100);
      goto_pg(200);
      do_cmd(215, 8, 3);
      for (int i = 0; i < 4; i++) begin
         fast = 1; set_ph(19);
         do_cmd($urandom_range(0, P - 1), $urandom_range(0, 4), -1);
         chk("rand_cmd_pg", abspg, mpg);
      end
      fast = 1; set_ph(19);
      issue_start(3000, 2);
      n = 0;
`ifdef K005297_ABSPG_TIMEOUT_EN
      while (!cnt_stop && n < P + 30) begin clk1(); if (last_tick) n++; end
      chk("tmo_ticks", n, P + 1);
      chk("tmo_err", seek_err, 1);
      chk("tmo_stop", cnt_stop, 1);
      bsen_n = 1; clk1();
      chk("tmo_idle", busy, 0);
      chk("tmo_err_hold", seek_err, 1);
      cmd_req = 1; tgt_pg = 0; clk1(); cmd_req = 0;
      chk("tmo_err_clr", seek_err, 0);
      abort = 1; clk1(); abort = 0;
      chk("abort_start_idle", busy, 0);
`else
      repeat (P + 30) begin clk1(); if (last_tick) n++; end
      chk("seek_ticks", n, P + 30);
      chk("seek_busy", busy, 1);
      chk("seek_nostop", cnt_stop, 0);
      chk("seek_err", seek_err, 0);
      abort = 1; clk1(); abort = 0;
      chk("abort_seek_stop", cnt_stop, 1);
      bsen_n = 1; clk1();
      chk("abort_seek_idle", busy, 0);
`endif
      issue_start((mpg + 1000) % P, 3);
      repeat (5) clk1();
      rst_n = 0;
      #1;
      chk("mid_rst_pg", abspg, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_stop", cnt_stop, 0);
      mpg = 0;
      clk1();
      rst_n = 1;
      repeat (3) clk1();
      chk("post_rst_pg", abspg, mpg);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
